result_readout: RTL and testbench



---
 rtl/readout_pkg.sv | 21 ++
 rtl/result_readout_rot_click_detect.sv | 42 ++++
 rtl/result_readout.sv | 137 +++++++++++++
 tb/tb_result_readout.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types and seven-segment constants for the result read-back path.
package readout_pkg;

    typedef enum logic {
        FILL = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segments, bit order gfedcba
    localparam logic [6:0] SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        return SEG7[nib];
    endfunction

endpackage

// File: rtl/result_readout_rot_click_detect.sv
// Registers the rotary/button pins and turns them into one-cycle click and
// button-press pulses.
import readout_pkg::*;

module rot_click_detect (
    input  logic clk,
    input  logic rst,
    input  logic rot_a,
    input  logic rot_b,
    input  logic pb,
    output logic click,
    output logic pb_event
);

    logic a_s, b_s, pb_s, pb_q, armed;

    // A click needs a full detent: 00 arms it, 11 fires once and disarms.
    // Mixed 01/10 phases leave the arm state alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_s      <= 1'b0;
            b_s      <= 1'b0;
            pb_s     <= 1'b0;
            pb_q     <= 1'b0;
            armed    <= 1'b0;
            click    <= 1'b0;
            pb_event <= 1'b0;
        end else begin
            a_s      <= rot_a;
            b_s      <= rot_b;
            pb_s     <= pb;
            pb_q     <= pb_s;
            pb_event <= pb_s & ~pb_q;
            click    <= armed & a_s & b_s;
            if (!a_s && !b_s)
                armed <= 1'b1;
            else if (a_s && b_s)
                armed <= 1'b0;
        end
    end

endmodule

// File: rtl/result_readout.sv
// Captures decoded nibbles from the receiver and steps through them on rotary
// clicks. Optional READOUT_AUTOSTEP_EN adds a periodic auto-advance in SHOW.
import readout_pkg::*;

module result_readout #(
    parameter int DEPTH       = 256,
    parameter int AUTO_PERIOD = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_nibble,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       rot_a,
    input  logic       rot_b,
    input  logic       PB1,
    output logic [7:0] led,
    output logic [6:0] lcd,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);

    state_t          state, state_nx;
    logic [AW-1:0]   wr_ptr, wr_ptr_nx;
    logic [AW-1:0]   rd_ptr, rd_ptr_nx;
    logic [AW:0]     count, count_nx;
    logic [3:0]      mem [DEPTH];
    logic            click, pb_event, advance, accept;

    rot_click_detect u_click (
        .clk      (clk),
        .rst      (rst),
        .rot_a    (rot_a),
        .rot_b    (rot_b),
        .pb       (PB1),
        .click    (click),
        .pb_event (pb_event)
    );

    assign in_ready = (state == FILL) && (count < CNT_FULL);
    assign busy     = (state == FILL);
    assign accept   = in_valid && in_ready;

`ifdef READOUT_AUTOSTEP_EN
    localparam int TW = $clog2(AUTO_PERIOD + 1);
    logic [TW-1:0] auto_cnt;
    logic          auto_tick;

    assign auto_tick = (state == SHOW) && (auto_cnt == TW'(AUTO_PERIOD - 1));

    // Held at zero outside SHOW so every entry starts a fresh period.
    always_ff @(posedge clk) begin
        if (rst || state != SHOW || click || auto_tick)
            auto_cnt <= '0;
        else
            auto_cnt <= auto_cnt + TW'(1);
    end

    assign advance = click | auto_tick;
`else
    assign advance = click;
`endif

    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        count_nx  = count;
        case (state)
            FILL: begin
                // A restart discards anything handshaked in the same cycle.
                if (pb_event) begin
                    wr_ptr_nx = '0;
                    count_nx  = '0;
                end else if (accept) begin
                    wr_ptr_nx = wr_ptr + PTR_ONE;
                    count_nx  = count + CNT_ONE;
                    if (in_last || count == CNT_LAST) begin
                        state_nx  = SHOW;
                        rd_ptr_nx = '0;
                    end
                end
            end
            SHOW: begin
                if (pb_event) begin
                    state_nx  = FILL;
                    wr_ptr_nx = '0;
                    count_nx  = '0;
                    rd_ptr_nx = '0;
                end else if (advance) begin
                    rd_ptr_nx = ({1'b0, rd_ptr} == count - CNT_ONE) ? '0 : rd_ptr + PTR_ONE;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_nx;
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            count  <= count_nx;
        end
    end

    // Buffer survives reset so a capture can still be inspected afterwards.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= in_nibble;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 8'h00;
            lcd <= SEG_BLANK;
        end else if (state == FILL) begin
            led <= 8'(wr_ptr);
            lcd <= SEG_BLANK;
        end else begin
            led <= 8'(rd_ptr);
            lcd <= hex7seg(mem[rd_ptr]);
        end
    end

endmodule

// File: tb/tb_result_readout.sv
// Directed and randomized checks of result_readout against a queue-level model
// of capture, readback index and display.
module tb_result_readout;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last, in_ready;
    logic [3:0] in_nibble;
    logic       rot_a, rot_b, PB1;
    logic [7:0] led;
    logic [6:0] lcd;
    logic       busy;

    always #5 clk = ~clk;

    result_readout #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_nibble (in_nibble),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .rot_a     (rot_a),
        .rot_b     (rot_b),
        .PB1       (PB1),
        .led       (led),
        .lcd       (lcd),
        .busy      (busy)
    );

    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0] EXP_SEQ [5] = '{7'h5B, 7'h71, 7'h3F, 7'h7C, 7'h5B};

    int errors = 0;
    int checks = 0;

    // Model: captured string, its length, and which entry the operator views
    bit m_show;
    int m_cnt, m_idx;
    int m_buf [DEPTH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_led, e_lcd;
        e_led = m_show ? 32'(m_idx) : 32'((m_cnt % DEPTH) & 255);
        e_lcd = m_show ? 32'(SEG[m_buf[m_idx][3:0]]) : 32'd0;
        check({tag, ".led"}, 32'(led), e_led);
        check({tag, ".lcd"}, 32'(lcd), e_lcd);
        check({tag, ".ready"}, 32'(in_ready), 32'(!m_show));
        check({tag, ".busy"}, 32'(busy), 32'(!m_show));
    endtask

    task automatic write(input logic [3:0] n, input logic last);
        in_valid  = 1'b1;
        in_nibble = n;
        in_last   = last;
        tick();
        if (!m_show && m_cnt < DEPTH) begin
            m_buf[m_cnt] = int'(n);
            m_cnt++;
            if (last || m_cnt == DEPTH) begin
                m_show = 1'b1;
                m_idx  = 0;
            end
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rot(input logic [1:0] ab);
        {rot_a, rot_b} = ab;
        tick();
    endtask

    task automatic click();
        rot(2'b00);
        rot(2'b11);
        rot(2'b00);
        if (m_show) m_idx = (m_idx + 1) % m_cnt;
    endtask

    task automatic press();
        PB1 = 1'b1;
        tick();
        PB1 = 1'b0;
        m_show = 1'b0;
        m_cnt  = 0;
        m_idx  = 0;
        settle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_nibble = 4'h0;
        rot_a = 1'b0; rot_b = 1'b0; PB1 = 1'b0;
        m_show = 1'b0; m_cnt = 0; m_idx = 0;
        tick(); tick();
        check_all("in_reset");
        rst = 1'b0;
        repeat (5) tick();
        check_all("reset_idle");

        // Fill to capacity with i%16, pausing once mid-way
        for (int i = 0; i < DEPTH; i++) begin
            write(4'(i % 16), 1'b0);
            if (i == 99) begin
                idle_in();
                settle();
                check_all("fill100");
            end
        end
        check("ready_after_full", 32'(in_ready), 32'd0);
        write(4'h5, 1'b0);
        idle_in();
        settle();
        check_all("full_show");
        check("full_lcd", 32'(lcd), 32'h3F);

        // Exact click-to-display latency
        {rot_a, rot_b} = 2'b11;
        tick();
        {rot_a, rot_b} = 2'b00;
        tick();
        tick();
        check("lat_t2_led", 32'(led), 32'h00);
        tick();
        check("lat_t3_led", 32'(led), 32'h01);
        check("lat_t3_lcd", 32'(lcd), 32'h06);
        m_idx = 1;
        for (int i = 0; i < DEPTH; i++) click();
        settle();
        check_all("wrap256");

        // Short capture terminated by in_last
        press();
        check_all("pb_fill");
        write(4'hB, 1'b0);
        write(4'h2, 1'b0);
        write(4'hF, 1'b0);
        write(4'h0, 1'b1);
        idle_in();
        settle();
        check_all("short_show");
        check("short_lcd0", 32'(lcd), 32'h7C);
        for (int i = 0; i < 5; i++) begin
            click();
            settle();
            check_all("short_click");
            check("short_seq", 32'(lcd), 32'(EXP_SEQ[i]));
        end

        // Half-detent does nothing, full detent through 01 advances once
        rot(2'b00); rot(2'b10); rot(2'b00);
        settle();
        check_all("half_detent");
        rot(2'b00); rot(2'b01); rot(2'b11); rot(2'b00);
        m_idx = (m_idx + 1) % m_cnt;
        settle();
        check_all("via_01");
        rot(2'b00);
        repeat (100) rot(2'b11);
        rot(2'b00);
        m_idx = (m_idx + 1) % m_cnt;
        settle();
        check_all("hold_11");

        // Button and click in the same cycle: button wins
        rot(2'b00);
        {rot_a, rot_b} = 2'b11;
        PB1 = 1'b1;
        tick();
        {rot_a, rot_b} = 2'b00;
        PB1 = 1'b0;
        tick();
        m_show = 1'b0; m_cnt = 0; m_idx = 0;
        settle();
        check_all("pb_vs_click");

        // Randomized captures with gaps and clicks
        for (int it = 0; it < 6; it++) begin
            int len, nclk;
            len = int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle_in();
                    tick();
                end
                write(4'($urandom), k == len - 1);
            end
            idle_in();
            settle();
            check_all("rnd_show");
            nclk = int'($urandom_range(0, 6));
            for (int k = 0; k < nclk; k++) begin
                click();
                settle();
                check_all("rnd_click");
            end
            press();
            check_all("rnd_pb");
        end

        // Reset mid-capture
        write(4'h1, 1'b0);
        write(4'h2, 1'b0);
        write(4'h3, 1'b0);
        idle_in();
        settle();
        check_all("pre_rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_show = 1'b0; m_cnt = 0; m_idx = 0;
        check_all("mid_rst");
        settle();
        check_all("post_rst");
        write(4'hA, 1'b1);
        idle_in();
        settle();
        check_all("after_rst_show");
        click();
        settle();
        check_all("after_rst_click");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
